// File: rtl/lrpt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lrpt_pkg
//  Description : Shared constants and types for the LRPT framing blocks:
//                unique-word table, UW length and the frame FSM state enum.
//  Revision    : 1.0  initial release
// ============================================================================
package lrpt_pkg;

    localparam int UW_LEN = 8;

    // Four UW variants packed MSB-first; bit 0 is the first bit of variant 0.
    localparam logic [0:31] SYNC_WORDS = 32'h274ED8B1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } frame_state_t;

    // Pick one of the four UW variants; rot 0 is the leftmost byte.
    function automatic logic [7:0] uw_select(input logic [1:0] rot);
        return SYNC_WORDS[{rot, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_out_reg
//  Description : Single-stage one-bit valid/ready output register for
//                bit-serial transmit blocks. Holds its bit while stalled and
//                emits a bubble when free with nothing to load.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_out_reg (
    input  logic clk,
    input  logic rst_in,
    input  logic load,
    input  logic din,
    input  logic ready_in,
    output logic out_free,
    output logic dout,
    output logic valid_out
);

    logic r_dout;
    logic r_valid;

    assign out_free  = !r_valid || ready_in;
    assign dout      = r_dout;
    assign valid_out = r_valid;

    // Advance the stage only when downstream has taken (or never had) the bit.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_dout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (out_free) begin
            r_valid <= load;
            if (load) begin
                r_dout <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uw_frame_inserter.sv
`default_nettype none
// ============================================================================
//  Module      : uw_frame_inserter
//  Description : Emits bursts of fixed-length frames, each an 8-bit unique
//                word (MSB first, one of four rotations) followed by payload
//                bits taken from a valid/ready hard-bit stream.
//  Revision    : 1.0  initial release
// ============================================================================
module uw_frame_inserter
    import lrpt_pkg::*;
#(
    parameter int BITS_PER_FRAME = 80,
    parameter int NUM_FRAMES     = 32
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic                              start,
    input  logic [1:0]                        rotation,
    input  logic                              hard_inp,
    input  logic                              valid_in,
    output logic                              ready_rx,
    output logic                              hard_out,
    output logic                              valid_out,
    input  logic                              ready_in,
    output logic                              busy,
    output logic [$clog2(NUM_FRAMES)-1:0]     frame_idx,
    output logic [$clog2(BITS_PER_FRAME)-1:0] bit_idx,
    output logic                              done
);

    localparam int c_FW = $clog2(NUM_FRAMES);
    localparam int c_BW = $clog2(BITS_PER_FRAME);

    localparam logic [c_BW-1:0] c_UW_LAST  = c_BW'(UW_LEN - 1);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(BITS_PER_FRAME - 1);
    localparam logic [c_FW-1:0] c_LAST_FRM = c_FW'(NUM_FRAMES - 1);

    frame_state_t    r_state, w_state_nxt;
    logic [c_BW-1:0] r_bit,   w_bit_nxt;
    logic [c_FW-1:0] r_frame, w_frame_nxt;
    logic [1:0]      r_rot,   w_rot_nxt;

    logic       w_load;
    logic       w_din;
    logic       w_done;
    logic       w_ready_rx;
    logic       w_out_free;
    logic [7:0] w_uw;

    assign w_uw      = uw_select(r_rot);
    assign busy      = (r_state != ST_IDLE);
    assign frame_idx = r_frame;
    assign bit_idx   = r_bit;
    assign done      = w_done;
    assign ready_rx  = w_ready_rx;

    // State, counters and latched rotation.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_bit   <= '0;
            r_frame <= '0;
            r_rot   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_frame <= w_frame_nxt;
            r_rot   <= w_rot_nxt;
        end
    end

    // Next-state, counter updates and output-stage load decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_frame_nxt = r_frame;
        w_rot_nxt   = r_rot;
        w_load      = 1'b0;
        w_din       = 1'b0;
        w_done      = 1'b0;
        w_ready_rx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_rot_nxt   = rotation;
                    w_frame_nxt = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_out_free) begin
                    w_load    = 1'b1;
                    // 7 - bit_idx over three bits is a bitwise inversion.
                    w_din     = w_uw[~r_bit[2:0]];
                    w_bit_nxt = r_bit + 1'b1;
                    if (r_bit == c_UW_LAST) begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                w_ready_rx = w_out_free;
                if (valid_in && w_out_free) begin
                    w_load = 1'b1;
                    w_din  = hard_inp;
                    if (r_bit == c_LAST_BIT) begin
                        w_bit_nxt = '0;
                        if (r_frame == c_LAST_FRM) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_frame_nxt = r_frame + 1'b1;
                            w_rot_nxt   = rotation;
                            w_state_nxt = ST_SYNC;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    bit_out_reg u_out (
        .clk       (clk),
        .rst_in    (rst_in),
        .load      (w_load),
        .din       (w_din),
        .ready_in  (ready_in),
        .out_free  (w_out_free),
        .dout      (hard_out),
        .valid_out (valid_out)
    );

endmodule
`default_nettype wire
